dp_ram_port_a_arbiter: RTL and testbench

- Round-robin arbiter sharing the single read/write port A of the two-read/one-write dual-port RAM among NUM_REQ requesters.
- Each requester issues single-word read or write requests over a REQ/ACK handshake.
- Registered RAM-side outputs drive the RAM port A address, data and write-enable pins directly.
- Read data comes back from port A DO. Port B is outside this block.

---
 rtl/dp_ram_port_a_arbiter.sv | 174 +++++++++++++++++
 tb/tb_dp_ram_port_a_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_port_a_arbiter.sv
// dp_ram_port_a_arbiter
//   Round-robin arbiter that shares port A of the dual-port RAM among
//   NUM_REQ requesters. Each requester issues single-word reads or writes
//   over a REQ/ACK handshake. Every output is registered, and the RAM-side
//   outputs drive the port A pins directly.
//
//   Optional feature: define RAM_ARB_LOCK_EN to add the LOCK input. When it
//   is defined, an owner that holds LOCK and REQ is regranted at
//   re-arbitration, without masking or rotation.
//
// Ports
//   CLK, RST        clock; synchronous active-high reset
//   REQ, REQ_WE     per-requester request and write (1) / read (0) select
//   REQ_ADDR/DATA   packed per-requester address / write data
//   LOCK            (RAM_ARB_LOCK_EN only) per-requester bus lock
//   ACK             one-cycle pulse: the request is issued to the RAM this cycle
//   GNT             one-hot owner of the current or last access; 0 when idle
//   RD_VALID        one-cycle pulse to the read requester, together with RD_DATA
//   RD_DATA         read data shared by all requesters
//   RAM_ADDR/DI/WE  port A address, write data and write enable
//   RAM_DO          port A read data, valid the cycle after the address
module dp_ram_port_a_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ-1:0]            REQ_WE,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
`ifdef RAM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            LOCK,
`endif
  output logic [NUM_REQ-1:0]            ACK,
  output logic [NUM_REQ-1:0]            GNT,
  output logic [NUM_REQ-1:0]            RD_VALID,
  output logic [DATA_WIDTH-1:0]         RD_DATA,
  output logic [ADDR_WIDTH-1:0]         RAM_ADDR,
  output logic [DATA_WIDTH-1:0]         RAM_DI,
  output logic                          RAM_WE,
  input  logic [DATA_WIDTH-1:0]         RAM_DO
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [NUM_REQ-1:0]      rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_di_q, ram_di_d;
  logic                    ram_we_q, ram_we_d;

  logic [NUM_REQ-1:0]      elig;
  logic [IDX_W:0]          win;
  logic                    lock_hold;
  logic                    grant_any;
  logic [IDX_W-1:0]        sel_idx;
  logic [NUM_REQ-1:0]      sel_onehot;
  logic                    arb_point;
  logic                    load;

  // Returns {found, index}: the first set bit of elig, searching from last+1 and wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req_v,
                                             input logic [IDX_W-1:0]   last);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] pos;
    int               idx;
    res = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last) + i) % NUM_REQ;
      pos = IDX_W'(idx);
      if (!res[IDX_W] && req_v[pos]) res = {1'b1, pos};
    end
    return res;
  endfunction

  // The requester acked this cycle still holds REQ and must not win again at once.
  assign elig = REQ & ~ack_q;
  assign win  = rr_pick(elig, last_q);

  // The owner's index always equals last_q, so a locked regrant reuses last_q.
`ifdef RAM_ARB_LOCK_EN
  assign lock_hold = |(gnt_q & LOCK & REQ);
`else
  assign lock_hold = 1'b0;
`endif

  assign grant_any = lock_hold | win[IDX_W];
  assign sel_idx   = lock_hold ? last_q : win[IDX_W-1:0];

  // The ISSUE cycle of a read cannot re-arbitrate: the RAM address must stay held.
  assign arb_point = (state_q == IDLE) || (state_q == RDATA) ||
                     ((state_q == ISSUE) && ram_we_q);
  assign load      = arb_point && grant_any;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      last_q     <= IDX_W'(NUM_REQ - 1);
      ack_q      <= '0;
      gnt_q      <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      ram_addr_q <= '0;
      ram_di_q   <= '0;
      ram_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      ack_q      <= ack_d;
      gnt_q      <= gnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      ram_addr_q <= ram_addr_d;
      ram_di_q   <= ram_di_d;
      ram_we_q   <= ram_we_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (load)
      state_d = ISSUE;
    else if ((state_q == ISSUE) && !ram_we_q)
      state_d = RDATA;
  end

  always_comb begin
    ack_d      = '0;
    rd_valid_d = '0;
    rd_data_d  = rd_data_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    ram_addr_d = ram_addr_q;
    ram_di_d   = ram_di_q;
    ram_we_d   = ram_we_q;
    sel_onehot = '0;
    sel_onehot[sel_idx] = 1'b1;

    if (state_q == RDATA) begin
      rd_data_d  = RAM_DO;
      rd_valid_d = gnt_q;
    end

    if (load) begin
      gnt_d      = sel_onehot;
      ack_d      = sel_onehot;
      last_d     = sel_idx;
      ram_addr_d = REQ_ADDR[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      ram_di_d   = REQ_DATA[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
      ram_we_d   = REQ_WE[sel_idx];
    end else if (state_q != IDLE) begin
      ram_we_d = 1'b0;
      // Going idle releases the grant; a read moving to RDATA keeps its owner.
      if (arb_point) gnt_d = '0;
    end
  end

  assign ACK      = ack_q;
  assign GNT      = gnt_q;
  assign RD_VALID = rd_valid_q;
  assign RD_DATA  = rd_data_q;
  assign RAM_ADDR = ram_addr_q;
  assign RAM_DI   = ram_di_q;
  assign RAM_WE   = ram_we_q;

endmodule

// File: tb/tb_dp_ram_port_a_arbiter.sv
module tb_dp_ram_port_a_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  REQ;
  logic [3:0]  REQ_WE;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_DATA;
  logic [3:0]  LOCK;
  logic [3:0]  ACK;
  logic [3:0]  GNT;
  logic [3:0]  RD_VALID;
  logic [7:0]  RD_DATA;
  logic [7:0]  RAM_ADDR;
  logic [7:0]  RAM_DI;
  logic        RAM_WE;
  logic [7:0]  RAM_DO;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  dp_ram_port_a_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ      (REQ),
    .REQ_WE   (REQ_WE),
    .REQ_ADDR (REQ_ADDR),
    .REQ_DATA (REQ_DATA),
`ifdef RAM_ARB_LOCK_EN
    .LOCK     (LOCK),
`endif
    .ACK      (ACK),
    .GNT      (GNT),
    .RD_VALID (RD_VALID),
    .RD_DATA  (RD_DATA),
    .RAM_ADDR (RAM_ADDR),
    .RAM_DI   (RAM_DI),
    .RAM_WE   (RAM_WE),
    .RAM_DO   (RAM_DO)
  );

  // Port A model: the write happens at the edge, the address is registered, and DO follows it.
  logic [7:0] mem [256];
  logic [7:0] ram_addr_reg = 8'h00;
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  always @(posedge CLK) begin
    if (RAM_WE) mem[RAM_ADDR] <= RAM_DI;
    ram_addr_reg <= RAM_ADDR;
  end
  assign RAM_DO = mem[ram_addr_reg];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [7:0] a, input logic [7:0] d);
    REQ_WE[i]        = we;
    REQ_ADDR[i*8 +: 8] = a;
    REQ_DATA[i*8 +: 8] = d;
  endtask

  initial begin
    RST = 1'b1; REQ = '0; REQ_WE = '0; REQ_ADDR = '0; REQ_DATA = '0; LOCK = '0;
    step(); step();
    chk("rst_ack", 32'(ACK), 32'h0);
    chk("rst_gnt", 32'(GNT), 32'h0);
    chk("rst_rdv", 32'(RD_VALID), 32'h0);
    chk("rst_we", 32'(RAM_WE), 32'h0);
    chk("rst_addr", 32'(RAM_ADDR), 32'h0);
    chk("rst_di", 32'(RAM_DI), 32'h0);
    chk("rst_rdd", 32'(RD_DATA), 32'h0);
    RST = 1'b0;

    // Single write by requester 2
    set_req(2, 1'b1, 8'h10, 8'hA5); REQ = 4'b0100;
    step();
    chk("t1_ack", 32'(ACK), 32'h4);
    chk("t1_gnt", 32'(GNT), 32'h4);
    chk("t1_we", 32'(RAM_WE), 32'h1);
    chk("t1_addr", 32'(RAM_ADDR), 32'h10);
    chk("t1_di", 32'(RAM_DI), 32'hA5);
    REQ = 4'b0000;
    step();
    chk("t1_ack_off", 32'(ACK), 32'h0);
    chk("t1_we_off", 32'(RAM_WE), 32'h0);
    chk("t1_gnt_off", 32'(GNT), 32'h0);

    // Write 0x10=0x3C by requester 0, then requester 1 reads 0x10 back-to-back
    set_req(0, 1'b1, 8'h10, 8'h3C); REQ = 4'b0001;
    step();
    chk("t2_wack", 32'(ACK), 32'h1);
    set_req(1, 1'b0, 8'h10, 8'h00); REQ = 4'b0010;
    step();
    chk("t2_rack", 32'(ACK), 32'h2);
    chk("t2_rwe", 32'(RAM_WE), 32'h0);
    chk("t2_raddr", 32'(RAM_ADDR), 32'h10);
    REQ = 4'b0000;
    step();
    chk("t2_rdv_early", 32'(RD_VALID), 32'h0);
    step();
    chk("t2_rdv", 32'(RD_VALID), 32'h2);
    chk("t2_rdd", 32'(RD_DATA), 32'h3C);
    chk("t2_gnt_idle", 32'(GNT), 32'h0);
    step();
    chk("t2_rdv_pulse", 32'(RD_VALID), 32'h0);

    // All four write continuously, starting from a fresh pointer
    RST = 1'b1; step(); RST = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(8'h20 + i), 8'(8'h50 + i));
    REQ = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("t3_ack%0d", k), 32'(ACK), 32'(4'b0001 << (k % 4)));
      chk($sformatf("t3_addr%0d", k), 32'(RAM_ADDR), 32'(8'h20 + (k % 4)));
      chk($sformatf("t3_we%0d", k), 32'(RAM_WE), 32'h1);
    end
    REQ = 4'b0000;
    step();
    chk("t3_idle_ack", 32'(ACK), 32'h0);
    chk("t3_idle_we", 32'(RAM_WE), 32'h0);

    // Simultaneous reads from requesters 0 and 3
    set_req(0, 1'b0, 8'h20, 8'h00); set_req(3, 1'b0, 8'h23, 8'h00);
    REQ = 4'b1001;
    step();
    chk("t4_ack0", 32'(ACK), 32'h1);
    REQ = 4'b1000;
    step();
    chk("t4_rdata_ack", 32'(ACK), 32'h0);
    chk("t4_rdata_rdv", 32'(RD_VALID), 32'h0);
    step();
    chk("t4_rdv0", 32'(RD_VALID), 32'h1);
    chk("t4_rdd0", 32'(RD_DATA), 32'h50);
    chk("t4_ack3", 32'(ACK), 32'h8);
    REQ = 4'b0000;
    step();
    chk("t4_gap", 32'(RD_VALID), 32'h0);
    step();
    chk("t4_rdv3", 32'(RD_VALID), 32'h8);
    chk("t4_rdd3", 32'(RD_DATA), 32'h53);

    // Reset during the RDATA cycle drops the read
    set_req(2, 1'b0, 8'h22, 8'h00); REQ = 4'b0100;
    step();
    chk("t5_ack2", 32'(ACK), 32'h4);
    REQ = 4'b0000;
    step();
    RST = 1'b1;
    step();
    chk("t5_rdv", 32'(RD_VALID), 32'h0);
    chk("t5_ack", 32'(ACK), 32'h0);
    chk("t5_gnt", 32'(GNT), 32'h0);
    chk("t5_addr", 32'(RAM_ADDR), 32'h0);
    chk("t5_rdd", 32'(RD_DATA), 32'h0);
    RST = 1'b0;
    step();
    chk("t5_rdv_after", 32'(RD_VALID), 32'h0);
    set_req(0, 1'b1, 8'h30, 8'h11); set_req(3, 1'b1, 8'h33, 8'h44);
    REQ = 4'b1001;
    step();
    chk("t5_first0", 32'(ACK), 32'h1);
    step();
    chk("t5_then3", 32'(ACK), 32'h8);
    REQ = 4'b0000;
    step();

    // A lone requester holding REQ is granted on alternate cycles
    set_req(1, 1'b1, 8'h40, 8'h77); REQ = 4'b0010;
    step();
    chk("alt_a", 32'(ACK), 32'h2);
    step();
    chk("alt_b", 32'(ACK), 32'h0);
    chk("alt_b_we", 32'(RAM_WE), 32'h0);
    step();
    chk("alt_c", 32'(ACK), 32'h2);
    REQ = 4'b0000;
    step();
    chk("alt_d", 32'(ACK), 32'h0);

`ifdef RAM_ARB_LOCK_EN
    // A locked owner is regranted every cycle while a competitor waits
    RST = 1'b1; step(); RST = 1'b0;
    set_req(1, 1'b1, 8'h60, 8'h61); set_req(2, 1'b1, 8'h62, 8'h63);
    LOCK = 4'b0010; REQ = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t6_lock%0d", k), 32'(ACK), 32'h2);
    end
    LOCK = 4'b0000; REQ = 4'b0100;
    step();
    chk("t6_ack2", 32'(ACK), 32'h4);
    REQ = 4'b0000;
    step();
    chk("t6_idle", 32'(ACK), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
